// File: rtl/fadd_arbiter.sv
// fadd_arbiter: two requesters share one pipelined single-precision adder.
// A round-robin pointer picks a winner each cycle, and the winner's operands
// are registered toward the unit. Subtraction is done by flipping the x2 sign.
// A {valid, tag} shift register follows each operation through the unit, so
// each result goes back to the requester that issued it.
// Optional feature: define FADD_ARB_OVF_STICKY_EN to add per-requester
// sticky overflow flags with the ovf_clr / ovf_sticky ports.

// Response register for one requester. It loads only when a result tagged
// for it comes back, so the last value stays until the next one arrives.
module fadd_arb_rsp_lane (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        i_ret,
  input  logic [31:0] i_y,
  input  logic        i_ovf,
`ifdef FADD_ARB_OVF_STICKY_EN
  input  logic        i_clr,
  output logic        o_sticky,
`endif
  output logic        o_valid,
  output logic [31:0] o_y,
  output logic        o_ovf
);

  // One-cycle valid pulse; payload held between returns.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      o_valid <= 1'b0;
      o_y     <= '0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= i_ret;
      if (i_ret) begin
        o_y   <= i_y;
        o_ovf <= i_ovf;
      end
    end
  end

`ifdef FADD_ARB_OVF_STICKY_EN
  // Sticky overflow: a new overflow response beats a same-cycle clear.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) o_sticky <= 1'b0;
    else         o_sticky <= (o_sticky & ~i_clr) | (i_ret & i_ovf);
  end
`endif

endmodule

module fadd_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  input  logic        req0_sub,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_sub,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        req1_ready,
  output logic [31:0] fu_x1,
  output logic [31:0] fu_x2,
  input  logic [31:0] fu_y,
  input  logic        fu_ovf,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_y,
  output logic        rsp0_ovf,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_y,
  output logic        rsp1_ovf
`ifdef FADD_ARB_OVF_STICKY_EN
  ,
  input  logic        ovf_clr,
  output logic [1:0]  ovf_sticky
`endif
);

  localparam int NREQ = 2;

  typedef struct packed {
    logic        vld;
    logic        sub;
    logic [31:0] x1;
    logic [31:0] x2;
  } req_t;

  req_t [NREQ-1:0]        w_req;
  req_t                   w_win;
  logic [NREQ-1:0]        w_vld;
  logic [NREQ-1:0]        w_gnt;
  logic                   w_xfer;
  logic                   w_sel;
  logic [31:0]            w_op_x2;
  logic [NREQ-1:0]        w_ret;
  logic [NREQ-1:0]        w_rsp_valid;
  logic [NREQ-1:0][31:0]  w_rsp_y;
  logic [NREQ-1:0]        w_rsp_ovf;

  logic                   r_ptr;        // 0 favours requester 0
  logic [31:0]            r_fu_x1;
  logic [31:0]            r_fu_x2;
  logic [LATENCY:0]       r_vld_pipe;   // [0] = issue valid, [LATENCY] aligned with fu_y
  logic [LATENCY:0]       r_tag_pipe;

  assign w_req[0] = {req0_valid, req0_sub, req0_x1, req0_x2};
  assign w_req[1] = {req1_valid, req1_sub, req1_x1, req1_x2};

  // Grant: only one valid requester wins, on a tie the pointer decides.
  // Reset gates the readies, so nothing is granted while rstn is low.
  always_comb begin
    w_vld[0] = w_req[0].vld & rstn;
    w_vld[1] = w_req[1].vld & rstn;
    w_gnt[0] = w_vld[0] & (~w_vld[1] | ~r_ptr);
    w_gnt[1] = w_vld[1] & (~w_vld[0] |  r_ptr);
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_xfer     = |w_gnt;
  assign w_sel      = w_gnt[1];
  assign w_win      = w_req[w_sel];

  // A subtract is an add with the sign of x2 flipped. Zero/denormal/inf/NaN
  // encodings go through untouched.
  assign w_op_x2 = w_win.sub ? {~w_win.x2[31], w_win.x2[30:0]} : w_win.x2;

  // The pointer moves only on a transfer, so it then favours the loser.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_ptr <= 1'b0;
    else if (w_xfer) r_ptr <= ~w_sel;
  end

  // Operand registers to the shared unit; they hold when nothing is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fu_x1 <= '0;
      r_fu_x2 <= '0;
    end else if (w_xfer) begin
      r_fu_x1 <= w_win.x1;
      r_fu_x2 <= w_op_x2;
    end
  end

  assign fu_x1 = r_fu_x1;
  assign fu_x2 = r_fu_x2;

  // {valid, tag} tracking. Reset clears the valids, so operations that were
  // in flight get no response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[LATENCY-1:0], w_xfer};
      r_tag_pipe <= {r_tag_pipe[LATENCY-1:0], w_sel};
    end
  end

  for (genvar n = 0; n < NREQ; n++) begin : g_lane
    assign w_ret[n] = r_vld_pipe[LATENCY] & (r_tag_pipe[LATENCY] == 1'(n));

    fadd_arb_rsp_lane u_lane (
      .gclk     (clk),
      .grst_n   (rstn),
      .i_ret    (w_ret[n]),
      .i_y      (fu_y),
      .i_ovf    (fu_ovf),
`ifdef FADD_ARB_OVF_STICKY_EN
      .i_clr    (ovf_clr),
      .o_sticky (ovf_sticky[n]),
`endif
      .o_valid  (w_rsp_valid[n]),
      .o_y      (w_rsp_y[n]),
      .o_ovf    (w_rsp_ovf[n])
    );
  end

  assign rsp0_valid = w_rsp_valid[0];
  assign rsp0_y     = w_rsp_y[0];
  assign rsp0_ovf   = w_rsp_ovf[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp1_y     = w_rsp_y[1];
  assign rsp1_ovf   = w_rsp_ovf[1];

endmodule
